// File: rtl/regfile_pkg.sv
// Shared widths and types for the RISC-V integer register file.
// Imported by the register file and by stages that carry register selects.
package regfile_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 4;
  localparam int NUM_REGS = 16;

  localparam logic [ADDR_W-1:0] ZERO_REG = 4'd0;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/register_file.sv
// 16 x 32 register file: two combinational reads, one clocked write.
// Register 0 always reads zero and ignores writes.
module register_file
  import regfile_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] Rs,
  input  logic [ADDR_W-1:0] Rt,
  input  logic [ADDR_W-1:0] Rd,
  input  logic [DATA_W-1:0] write_value,
  input  logic              regwrite,
  output logic [DATA_W-1:0] read_value1,
  output logic [DATA_W-1:0] read_value2
);

  reg_data_t regs [NUM_REGS];

  logic we;
  assign we = regwrite && (Rd != ZERO_REG);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= '0;
    end else if (we) begin
      regs[Rd] <= write_value;
    end
  end

  // No bypass: a same-cycle write shows up only after the edge.
  always_comb begin
    read_value1 = '0;
    read_value2 = '0;
    if (Rs != ZERO_REG)
      read_value1 = regs[Rs];
    if (Rt != ZERO_REG)
      read_value2 = regs[Rt];
  end

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file.
// Expected reads go into a scoreboard queue and are popped at sampling.
module tb_register_file;
  import regfile_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  Rs = '0;
  logic [3:0]  Rt = '0;
  logic [3:0]  Rd = '0;
  logic [31:0] write_value = '0;
  logic        regwrite = 1'b0;
  logic [31:0] read_value1;
  logic [31:0] read_value2;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       tag;
    logic [31:0] v1;
    logic [31:0] v2;
  } exp_t;

  exp_t sb [$];

  register_file dut (
    .clk         (clk),
    .reset       (reset),
    .Rs          (Rs),
    .Rt          (Rt),
    .Rd          (Rd),
    .write_value (write_value),
    .regwrite    (regwrite),
    .read_value1 (read_value1),
    .read_value2 (read_value2)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wr(logic [3:0] a, logic [31:0] v);
    @(negedge clk);
    Rd = a;
    write_value = v;
    regwrite = 1'b1;
    @(posedge clk);
    #1;
    regwrite = 1'b0;
  endtask

  task automatic rd(string tag, logic [3:0] s, logic [3:0] t,
                    logic [31:0] e1, logic [31:0] e2);
    exp_t e;
    e.tag = tag;
    e.v1 = e1;
    e.v2 = e2;
    sb.push_back(e);
    Rs = s;
    Rt = t;
  endtask

  task automatic sample();
    exp_t e;
    #1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL sb_empty got=0 exp=1");
    end else begin
      e = sb.pop_front();
      check({e.tag, "_p1"}, read_value1, e.v1);
      check({e.tag, "_p2"}, read_value2, e.v2);
    end
  endtask

  logic [31:0] model [16];

  initial begin
    rd("in_reset", 4'd7, 4'd3, 32'h0, 32'h0);
    sample();
    @(negedge clk);
    reset = 1'b1;

    wr(4'd7, 32'hFFFF_FFFF);
    rd("r7_written", 4'd7, 4'd0, 32'hFFFF_FFFF, 32'h0);
    sample();
    reset = 1'b0;
    rd("async_clear", 4'd7, 4'd7, 32'h0, 32'h0);
    sample();
    reset = 1'b1;
    rd("after_rst", 4'd7, 4'd1, 32'h0, 32'h0);
    sample();

    wr(4'd2, 32'hAAAA_BBBB);
    wr(4'd3, 32'hCCCC_DDDD);
    rd("pair1", 4'd2, 4'd3, 32'hAAAA_BBBB, 32'hCCCC_DDDD);
    sample();

    wr(4'd4, 32'h1234_5678);
    wr(4'd5, 32'h9876_5432);
    rd("pair2", 4'd4, 4'd5, 32'h1234_5678, 32'h9876_5432);
    sample();

    wr(4'd0, 32'hDEAD_BEEF);
    rd("r0_prot", 4'd0, 4'd2, 32'h0, 32'hAAAA_BBBB);
    sample();

    @(negedge clk);
    Rd = 4'd2;
    write_value = 32'h5555_5555;
    regwrite = 1'b0;
    repeat (3) @(posedge clk);
    rd("we_off", 4'd2, 4'd2, 32'hAAAA_BBBB, 32'hAAAA_BBBB);
    sample();

    @(negedge clk);
    Rd = 4'd6;
    write_value = 32'h0BAD_F00D;
    regwrite = 1'b1;
    rd("same_pre", 4'd6, 4'd6, 32'h0, 32'h0);
    sample();
    @(posedge clk);
    rd("same_post", 4'd6, 4'd6, 32'h0BAD_F00D, 32'h0BAD_F00D);
    sample();
    regwrite = 1'b0;

    wr(4'd8, 32'h1111_1111);
    wr(4'd8, 32'h2222_2222);
    rd("second_wins", 4'd8, 4'd0, 32'h2222_2222, 32'h0);
    sample();

    model[0] = '0;
    for (int i = 1; i < 16; i++) begin
      model[i] = $urandom();
      wr(4'(i), model[i]);
    end
    for (int i = 0; i < 16; i++) begin
      rd($sformatf("sweep%0d", i), 4'(i), 4'(15 - i),
         model[i], model[15 - i]);
      sample();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
